// File: rtl/l1d_wb_pkg.sv
// rtl/l1d_wb_pkg.sv - shared constants, state enum and entry type for the L1D write buffer
//
// Purpose : default geometry, the controller state encoding and the buffered
//           entry record. The entry record is sized to the default widths; the
//           top zero-extends narrower ADDR_W/DATA_W into it, so instance widths
//           must not exceed DEF_ADDR_W/DEF_DATA_W.
// Ports   : none (package)

package l1d_wb_pkg;

  localparam int DEF_DEPTH  = 4;
  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;
  localparam int SIZE_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
    logic [SIZE_W-1:0]     size;
  } wb_entry_t;

endpackage

// File: rtl/l1d_wb_if.sv
// rtl/l1d_wb_if.sv - write, forwarding-lookup and L2 drain channels of the write buffer
//
// Purpose : bundles the three handshake/bus channels.
// Ports   : master = L1D/L2 side (drives wr_*, rd_addr, l2_ready)
//           slave  = write buffer (drives wr_ready, rd_hit/rd_data, l2_valid/l2_addr/l2_data/l2_size)

interface l1d_wb_if #(
  parameter int ADDR_W = l1d_wb_pkg::DEF_ADDR_W,
  parameter int DATA_W = l1d_wb_pkg::DEF_DATA_W
);
  logic                          wr_valid;
  logic                          wr_ready;
  logic [ADDR_W-1:0]             wr_addr;
  logic [DATA_W-1:0]             wr_data;
  logic [l1d_wb_pkg::SIZE_W-1:0] wr_size;

  logic [ADDR_W-1:0]             rd_addr;
  logic                          rd_hit;
  logic [DATA_W-1:0]             rd_data;

  logic                          l2_valid;
  logic                          l2_ready;
  logic [ADDR_W-1:0]             l2_addr;
  logic [DATA_W-1:0]             l2_data;
  logic [l1d_wb_pkg::SIZE_W-1:0] l2_size;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_size, rd_addr, l2_ready,
    input  wr_ready, rd_hit, rd_data, l2_valid, l2_addr, l2_data, l2_size
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_size, rd_addr, l2_ready,
    output wr_ready, rd_hit, rd_data, l2_valid, l2_addr, l2_data, l2_size
  );
endinterface

// File: rtl/l1d_wb_cam.sv
// rtl/l1d_wb_cam.sv - youngest-match address lookup for store-to-load forwarding
//
// Purpose : compares i_addr against every occupied entry and returns the data
//           of the youngest matching one.
// Ports   : i_tag/i_val - per-slot address/data; i_head/i_count - occupancy window;
//           i_addr - lookup address; o_hit/o_data - match flag and data (0 on miss)

module l1d_wb_cam
  import l1d_wb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic [DEF_ADDR_W-1:0]    i_tag [DEPTH],
  input  logic [DEF_DATA_W-1:0]    i_val [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] i_head,
  input  logic [$clog2(DEPTH):0]   i_count,
  input  logic [DEF_ADDR_W-1:0]    i_addr,
  output logic                     o_hit,
  output logic [DEF_DATA_W-1:0]    o_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    v_idx  = '0;
    o_hit  = 1'b0;
    o_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = i_head + PTR_W'(k);
      if ((CNT_W'(k) < i_count) && (i_tag[v_idx] == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_val[v_idx];
      end
    end
  end

endmodule

// File: rtl/l1d_write_buffer.sv
// rtl/l1d_write_buffer.sv - L1D write-through buffer draining to L2 with forwarding and flush
//
// Purpose : circular FIFO of DEPTH write entries between L1D and L2. Supports
//           store-to-load forwarding and a cache-line-flush drain.
//           Optional macro L1D_WB_COALESCE_EN merges a push into the youngest
//           entry when address and size match (never into the head).
// Ports   : i_clk, i_rst (sync, active high), i_flush - flush request,
//           o_flush_done - one-cycle completion pulse, o_count - occupancy,
//           io_wb - write / lookup / L2 channels (slave side)

module l1d_write_buffer
  import l1d_wb_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  output logic                   o_flush_done,
  output logic [$clog2(DEPTH):0] o_count,
  l1d_wb_if.slave                io_wb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  wb_state_e        r_state;
  logic             r_flush_done;

  logic             w_wr_ready;
  logic             w_l2_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_coalesce;
  logic             w_alloc;
  logic [PTR_W-1:0] w_wr_idx;
  logic [CNT_W-1:0] w_count_nxt;
  wb_entry_t        w_new;
  wb_entry_t        w_head_ent;
  logic             w_cam_hit;
  logic             w_rd_hit;
  logic [DEF_DATA_W-1:0] w_cam_data;
  logic [DEF_ADDR_W-1:0] w_tag [DEPTH];
  logic [DEF_DATA_W-1:0] w_val [DEPTH];

  assign w_wr_ready = !i_rst && (r_count < FULL_CNT) && (r_state != FLUSH);
  assign w_l2_valid = !i_rst && (r_count != '0);
  assign w_push     = io_wb.wr_valid && w_wr_ready;
  assign w_pop      = w_l2_valid && io_wb.l2_ready;

  assign w_new = '{addr: DEF_ADDR_W'(io_wb.wr_addr),
                   data: DEF_DATA_W'(io_wb.wr_data),
                   size: io_wb.wr_size};

`ifdef L1D_WB_COALESCE_EN
  logic [PTR_W-1:0] w_young;
  assign w_young = r_tail - PTR_W'(1);
  // The head is excluded: it is on the L2 bus and may be consumed this cycle.
  assign w_coalesce = w_push && (r_count != '0) && (w_young != r_head) &&
                      (r_mem[w_young].addr == w_new.addr) &&
                      (r_mem[w_young].size == w_new.size);
  assign w_wr_idx   = w_coalesce ? w_young : r_tail;
`else
  assign w_coalesce = 1'b0;
  assign w_wr_idx   = r_tail;
`endif

  assign w_alloc     = w_push && !w_coalesce;
  assign w_count_nxt = r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);

  // A coalescing write rewrites identical addr/size, so the whole record is stored either way.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[w_wr_idx] <= w_new;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_state      <= IDLE;
      r_flush_done <= 1'b0;
    end else begin
      r_count      <= w_count_nxt;
      r_flush_done <= 1'b0;
      if (w_alloc) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)   r_head <= r_head + PTR_W'(1);
      case (r_state)
        // A repeated flush request is ignored here; only emptiness ends the flush.
        FLUSH: begin
          if (w_count_nxt == '0) begin
            r_state      <= IDLE;
            r_flush_done <= 1'b1;
          end
        end
        default: begin
          if (i_flush) begin
            if (w_count_nxt == '0) begin
              r_state      <= IDLE;
              r_flush_done <= 1'b1;
            end else begin
              r_state <= FLUSH;
            end
          end else begin
            r_state <= (w_count_nxt == '0) ? IDLE : DRAIN;
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cam_in
    assign w_tag[g] = r_mem[g].addr;
    assign w_val[g] = r_mem[g].data;
  end

  l1d_wb_cam #(.DEPTH(DEPTH)) u_cam (
    .i_tag   (w_tag),
    .i_val   (w_val),
    .i_head  (r_head),
    .i_count (r_count),
    .i_addr  (DEF_ADDR_W'(io_wb.rd_addr)),
    .o_hit   (w_cam_hit),
    .o_data  (w_cam_data)
  );

  assign w_head_ent     = r_mem[r_head];
  assign w_rd_hit       = !i_rst && w_cam_hit;

  assign io_wb.wr_ready = w_wr_ready;
  assign io_wb.l2_valid = w_l2_valid;
  assign io_wb.l2_addr  = w_l2_valid ? ADDR_W'(w_head_ent.addr) : '0;
  assign io_wb.l2_data  = w_l2_valid ? DATA_W'(w_head_ent.data) : '0;
  assign io_wb.l2_size  = w_l2_valid ? w_head_ent.size : '0;
  assign io_wb.rd_hit   = w_rd_hit;
  assign io_wb.rd_data  = w_rd_hit ? DATA_W'(w_cam_data) : '0;
  assign o_count        = r_count;
  assign o_flush_done   = r_flush_done;

endmodule

// File: tb/tb_l1d_write_buffer.sv
// tb/tb_l1d_write_buffer.sv - directed self-checking bench for l1d_write_buffer

module tb_l1d_write_buffer;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       flush_done;
  logic [2:0] count;
  int         n_tests;
  int         n_fail;

`ifdef L1D_WB_COALESCE_EN
  localparam logic [63:0] EXP_MERGE_CNT  = 64'd2;
  localparam logic [63:0] EXP_MERGE_NEXT = 64'h3;
`else
  localparam logic [63:0] EXP_MERGE_CNT  = 64'd3;
  localparam logic [63:0] EXP_MERGE_NEXT = 64'h2;
`endif

  l1d_wb_if #(.ADDR_W(64), .DATA_W(64)) wb ();

  l1d_write_buffer #(.DEPTH(4), .ADDR_W(64), .DATA_W(64)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_flush      (flush),
    .o_flush_done (flush_done),
    .o_count      (count),
    .io_wb        (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] d, input logic [2:0] s);
    wb.wr_valid = 1'b1;
    wb.wr_addr  = a;
    wb.wr_data  = d;
    wb.wr_size  = s;
    step();
    wb.wr_valid = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; flush = 1'b0;
    wb.wr_valid = 1'b0; wb.wr_addr = '0; wb.wr_data = '0; wb.wr_size = '0;
    wb.rd_addr = '0; wb.l2_ready = 1'b0;
    repeat (2) step();

    check("rst_count",      64'(count), 64'd0);
    check("rst_wr_ready",   64'(wb.wr_ready), 64'd0);
    check("rst_l2_valid",   64'(wb.l2_valid), 64'd0);
    check("rst_rd_hit",     64'(wb.rd_hit), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    check("rst_l2_addr",    wb.l2_addr, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_wr_ready", 64'(wb.wr_ready), 64'd1);

    // single write, no bypass
    wb.l2_ready = 1'b1;
    wb.wr_valid = 1'b1; wb.wr_addr = 64'h40; wb.wr_data = 64'h1234; wb.wr_size = 3'd2;
    #1;
    check("no_bypass_l2_valid", 64'(wb.l2_valid), 64'd0);
    step();
    wb.wr_valid = 1'b0;
    check("single_count",   64'(count), 64'd1);
    check("single_l2_valid", 64'(wb.l2_valid), 64'd1);
    check("single_l2_addr", wb.l2_addr, 64'h40);
    check("single_l2_data", wb.l2_data, 64'h1234);
    check("single_l2_size", 64'(wb.l2_size), 64'd2);
    step();
    check("single_drained", 64'(count), 64'd0);
    check("single_l2_idle", 64'(wb.l2_valid), 64'd0);

    // full buffer; tail wraps because head/tail start at 1
    wb.l2_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(64'h100 + 64'(i) * 64'h10, 64'h1000 + 64'(i), 3'd0);
    check("full_count",    64'(count), 64'd4);
    check("full_wr_ready", 64'(wb.wr_ready), 64'd0);
    push(64'h200, 64'h2000, 3'd0);
    check("full_held_off", 64'(count), 64'd4);
    check("full_head",     wb.l2_addr, 64'h100);
    wb.l2_ready = 1'b1;
    step();
    wb.l2_ready = 1'b0;
    check("full_pop_count", 64'(count), 64'd3);
    check("full_pop_ready", 64'(wb.wr_ready), 64'd1);
    check("full_pop_head",  wb.l2_addr, 64'h110);
    wb.rd_addr = 64'h130;
    #1;
    check("full_fwd_data", wb.rd_data, 64'h1003);
    wb.l2_ready = 1'b1;
    repeat (3) step();
    wb.l2_ready = 1'b0;
    check("full_drained", 64'(count), 64'd0);

    // forwarding, youngest wins
    push(64'h80, 64'hAA, 3'd0);
    push(64'h80, 64'hBB, 3'd0);
    wb.rd_addr = 64'h80;
    #1;
    check("fwd_hit",  64'(wb.rd_hit), 64'd1);
    check("fwd_data", wb.rd_data, 64'hBB);
    wb.rd_addr = 64'h88;
    #1;
    check("fwd_miss_hit",  64'(wb.rd_hit), 64'd0);
    check("fwd_miss_data", wb.rd_data, 64'd0);

    // simultaneous push and pop
    wb.l2_ready = 1'b1;
    push(64'h90, 64'hCC, 3'd0);
    check("pushpop_count", 64'(count), 64'd2);
    check("pushpop_head",  wb.l2_data, 64'hBB);
    wb.rd_addr = 64'h80;
    #1;
    check("fwd_popping_entry", wb.rd_data, 64'hBB);
    wb.l2_ready = 1'b0;
    push(64'hA0, 64'hDD, 3'd0);
    check("flush_pre_count", 64'(count), 64'd3);

    // flush with three entries
    flush = 1'b1; wb.l2_ready = 1'b1;
    step();
    flush = 1'b0; wb.wr_valid = 1'b1; wb.wr_addr = 64'h500;
    #1;
    check("flush_wr_ready_a", 64'(wb.wr_ready), 64'd0);
    check("flush_count_a",    64'(count), 64'd2);
    check("flush_done_a",     64'(flush_done), 64'd0);
    step();
    flush = 1'b1;
    check("flush_wr_ready_b", 64'(wb.wr_ready), 64'd0);
    check("flush_count_b",    64'(count), 64'd1);
    check("flush_done_b",     64'(flush_done), 64'd0);
    step();
    flush = 1'b0; wb.wr_valid = 1'b0;
    check("flush_count_c", 64'(count), 64'd0);
    check("flush_done_c",  64'(flush_done), 64'd1);
    step();
    check("flush_done_d",  64'(flush_done), 64'd0);
    check("flush_ready_d", 64'(wb.wr_ready), 64'd1);

    // flush while empty
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_empty_done", 64'(flush_done), 64'd1);
    step();
    check("flush_empty_clear", 64'(flush_done), 64'd0);

    // reset mid-drain discards entries and the pending flush
    wb.l2_ready = 1'b0;
    push(64'h300, 64'h3, 3'd1);
    push(64'h310, 64'h4, 3'd1);
    flush = 1'b1;
    step();
    flush = 1'b0; rst = 1'b1;
    #1;
    check("rst_mid_wr_ready", 64'(wb.wr_ready), 64'd0);
    step();
    rst = 1'b0;
    check("rst_mid_count",    64'(count), 64'd0);
    check("rst_mid_l2_valid", 64'(wb.l2_valid), 64'd0);
    check("rst_mid_done",     64'(flush_done), 64'd0);
    step();
    check("rst_mid_done_b",   64'(flush_done), 64'd0);
    check("rst_mid_ready",    64'(wb.wr_ready), 64'd1);

    // coalescing (head exempt)
    push(64'h100, 64'h1, 3'd3);
    push(64'h100, 64'h2, 3'd3);
    check("merge_head_exempt", 64'(count), 64'd2);
    push(64'h100, 64'h3, 3'd3);
    check("merge_count", 64'(count), EXP_MERGE_CNT);
    wb.rd_addr = 64'h100;
    #1;
    check("merge_fwd", wb.rd_data, 64'h3);
    wb.l2_ready = 1'b1;
    step();
    wb.l2_ready = 1'b0;
    check("merge_next_head", wb.l2_data, EXP_MERGE_NEXT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
